// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/ready request plus held result.
// The master drives the operands and start; the slave (the subtractor) drives status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output ready, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock.
// One full-subtractor cell plus a borrow flip-flop; result is held between operations.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_sr_nxt;
    logic [WIDTH-1:0] diff_r;
    logic             brw;
    logic             brw_nxt;
    logic             borrow_r;
    logic             d_bit;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // start is honoured in IDLE and DONE alike, which gives back-to-back operation
    assign accept = bus.start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign d_bit  = fs_diff(a_sr[0], b_sr[0], brw);
    assign brw_nxt = fs_borrow(a_sr[0], b_sr[0], brw);

    always_comb begin
        d_sr_nxt            = d_sr >> 1;
        d_sr_nxt[WIDTH-1]   = d_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            brw  <= bus.borrow_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            d_sr <= d_sr_nxt;
            brw  <= brw_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff_r   <= d_sr_nxt;
                borrow_r <= brw_nxt;
            end
        end
    end

    assign bus.ready      = (state != RUN);
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8, 4 and 1: randomized, directed and exhaustive
// operations checked against plain-arithmetic expectations, including completion timing.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(8)) i8 ();
    serial_subtractor_if #(.WIDTH(4)) i4 ();
    serial_subtractor_if #(.WIDTH(1)) i1 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8.slave));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));
    serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));

    typedef struct {
        longint diff;
        longint bo;
        int     due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];
    exp_t e8, e4, e1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int wof(input int which);
        case (which)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic rdy(input int which);
        case (which)
            0:       return i8.ready;
            1:       return i4.ready;
            default: return i1.ready;
        endcase
    endfunction

    task automatic drive(input int which, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic bi);
        case (which)
            0: begin i8.start = s; i8.a = av[7:0]; i8.b = bv[7:0]; i8.borrow_in = bi; end
            1: begin i4.start = s; i4.a = av[3:0]; i4.b = bv[3:0]; i4.borrow_in = bi; end
            default: begin i1.start = s; i1.a = av[0:0]; i1.b = bv[0:0]; i1.borrow_in = bi; end
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input int which, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input bit chk);
        int     guard = 0;
        int     w;
        longint mask, am, bm, r;
        exp_t   e;
        w = wof(which);
        while (!rdy(which) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 0, 1);
        drive(which, 1'b1, av, bv, bi);
        if (chk) begin
            mask  = (longint'(1) << w) - 1;
            am    = longint'(av) & mask;
            bm    = longint'(bv) & mask;
            r     = am - bm - longint'(bi);
            e.diff = r & mask;
            e.bo   = (am < bm + longint'(bi)) ? 1 : 0;
            e.due  = cyc + 1 + w;
            case (which)
                0:       q8.push_back(e);
                1:       q4.push_back(e);
                default: q1.push_back(e);
            endcase
        end
        @(negedge clk);
        drive(which, 1'b0, $urandom, $urandom, 1'($urandom));
    endtask

    // Watches the remaining RUN cycles of a W8 op; optionally pokes start at RUN cycle 3.
    task automatic watch_run(input bit poke);
        for (int i = 0; i < 8; i++) begin
            check("run_ready_low", longint'(i8.ready), 0);
            check("run_busy_high", longint'(i8.busy), 1);
            if (poke && i == 2) drive(0, 1'b1, 32'd55, 32'd200, 1'b1);
            if (poke && i == 3) drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q8.size() + q4.size() + q1.size()) != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", longint'(q8.size() + q4.size() + q1.size()), 0);
    endtask

    always @(negedge clk) begin
        if (i8.done) begin
            if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
            else begin
                e8 = q8.pop_front();
                check("w8_diff", longint'(i8.diff), e8.diff);
                check("w8_borrow", longint'(i8.borrow_out), e8.bo);
                check("w8_done_cycle", longint'(cyc), longint'(e8.due));
            end
        end
    end

    always @(negedge clk) begin
        if (i4.done) begin
            if (q4.size() == 0) check("w4_unexpected_done", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("w4_diff", longint'(i4.diff), e4.diff);
                check("w4_borrow", longint'(i4.borrow_out), e4.bo);
                check("w4_done_cycle", longint'(cyc), longint'(e4.due));
            end
        end
    end

    always @(negedge clk) begin
        if (i1.done) begin
            if (q1.size() == 0) check("w1_unexpected_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("w1_diff", longint'(i1.diff), e1.diff);
                check("w1_borrow", longint'(i1.borrow_out), e1.bo);
                check("w1_done_cycle", longint'(cyc), longint'(e1.due));
            end
        end
    end

    initial begin
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        drive(2, 1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_w8_ready", longint'(i8.ready), 1);
        check("rst_w8_busy", longint'(i8.busy), 0);
        check("rst_w8_done", longint'(i8.done), 0);
        check("rst_w8_diff", longint'(i8.diff), 0);
        check("rst_w8_borrow", longint'(i8.borrow_out), 0);
        check("rst_w4_ready", longint'(i4.ready), 1);
        check("rst_w4_busy", longint'(i4.busy), 0);
        check("rst_w1_ready", longint'(i1.ready), 1);
        check("rst_w1_done", longint'(i1.done), 0);

        // plain op with RUN observed cycle by cycle
        issue(0, 32'd100, 32'd37, 1'b0, 1'b1);
        watch_run(1'b0);
        drain();

        // negative results, then back-to-back
        issue(0, 32'd5, 32'd9, 1'b0, 1'b1);
        issue(0, 32'd0, 32'd0, 1'b1, 1'b1);
        drain();

        // start during RUN must be ignored
        issue(0, 32'd100, 32'd37, 1'b0, 1'b1);
        watch_run(1'b1);
        drain();

        // start held through DONE: second op follows with no idle cycle
        issue(0, 32'd17, 32'd3, 1'b1, 1'b1);
        issue(0, 32'd200, 32'd1, 1'b0, 1'b1);
        drain();

        // reset mid-RUN aborts with no done pulse
        issue(0, 32'd250, 32'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", longint'(i8.ready), 1);
        check("abort_busy", longint'(i8.busy), 0);
        check("abort_done", longint'(i8.done), 0);
        check("abort_diff", longint'(i8.diff), 0);
        check("abort_borrow", longint'(i8.borrow_out), 0);
        repeat (12) @(negedge clk);
        issue(0, 32'd9, 32'd250, 1'b1, 1'b1);
        drain();

        // randomized traffic with random idle gaps
        repeat (150) begin
            issue(0, $urandom, $urandom, 1'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain();

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    issue(1, 32'(a), 32'(b), 1'(bi), 1'b1);
        drain();

        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int bi = 0; bi < 2; bi++)
                    issue(2, 32'(a), 32'(b), 1'(bi), 1'b1);
        drain();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
